riscmacro_loader: RTL and testbench
===================================

// Module: riscmacro_loader
// PURPOSE
//  Program loader directly upstream of the riscmacro CPU top. Consumes a byte
//  stream (e.g. from a UART RX) framed as SYNC, 16-bit word count, N 32-bit
//  words and a checksum. Drives the CPU's override write port to fill memory,
//  and holds the CPU in reset until a load completes with a valid checksum.
// PARAMETERS
//  BIT_WIDTH       32     data/address width; matches the CPU
//  BASE_ADDR       0      address of the first loaded word
//  ADDR_STEP       4      address increment per word
//  SYNC_BYTE       8'hA5  frame start byte
//  TIMEOUT_CYCLES  100000 max idle cycles between bytes inside a frame
// PORTS
//  clk              in   1          clock, rising edge
//  reset            in   1          asynchronous, active-high
//  in_data          in   8          stream byte
//  in_valid         in   1          in_data valid
//  in_ready         out  1          loader accepts byte this cycle
//  override_memwrite out 1          one-cycle memory write strobe to the CPU
//  override_memread out  1          tied 0
//  override_rwaddr  out  BIT_WIDTH  write address
//  override_rwdata  out  BIT_WIDTH  write data
//  cpu_reset        out  1          reset to the CPU; high until a good load
//  load_done        out  1          last frame loaded and checksum OK
//  load_err         out  1          last frame failed (checksum or timeout)
// BEHAVIOUR
//  Reset: state=IDLE, cpu_reset=1, override_memwrite=0, addr=BASE_ADDR,
//   data=0, load_done=0, load_err=0, in_ready=1.
//  Byte accept = in_valid & in_ready at a rising clk edge. in_ready=1 in every
//   state except WRITE.
//  FSM:
//   IDLE: accept and discard bytes != SYNC_BYTE; SYNC_BYTE -> LEN_HI.
//   LEN_HI/LEN_LO: capture count[15:8]/[7:0]. After LEN_LO: count==0 -> CSUM,
//    else DATA. Address counter reloads BASE_ADDR; checksum clears on SYNC.
//   DATA: shift 4 bytes MSB-first into a word. On the 4th byte -> WRITE.
//   WRITE (1 cycle): override_memwrite=1 with rwaddr/rwdata stable. Next
//    cycle addr += ADDR_STEP (mod 2^BIT_WIDTH). Last word -> CSUM, else DATA.
//   CSUM: accept a byte. If (8-bit sum of len bytes + data bytes + this byte)
//    == 0 -> DONE, else ERR. SYNC is excluded from the sum.
//   DONE: load_done=1, cpu_reset=0. ERR: load_err=1, cpu_reset=1.
//   DONE/ERR: SYNC_BYTE -> LEN_HI. This clears load_done/load_err and
//    reasserts cpu_reset in the same edge. Other bytes are discarded.
//  cpu_reset is registered: it falls on the edge that accepts a good
//   checksum byte.
//  Timeout: in LEN_HI, LEN_LO, DATA or CSUM, a counter counts cycles without
//   a byte accept. When it reaches TIMEOUT_CYCLES -> ERR. The counter clears
//   on every accept and on every state entry. Partial words are dropped, and
//   words already written stay in memory.
//  override_rwaddr/rwdata hold their last values outside WRITE.
//  The checksum is 8 bits, modulo 256. The word count is unsigned, max 65535.
//  Async reset mid-frame: immediate return to the reset state. No write
//   strobe is issued after reset asserts.
// TESTING
//  1 Good load: A5 00 02 20 01 00 05 00 00 00 00 D8 -> two strobes:
//    addr 0 data 20010005, then addr 4 data 00000000. After the D8 edge:
//    load_done=1, cpu_reset=0, load_err=0.
//  2 Bad checksum: the same frame with last byte D9 -> both writes occur,
//    then load_err=1, cpu_reset=1, load_done=0.
//  3 Empty frame: A5 00 00 00 -> no strobes; load_done=1, cpu_reset=0.
//  4 Garbage then timeout: 11 22 A5 00 01 12 34, then stall TIMEOUT_CYCLES
//    -> bytes before A5 ignored; no strobe; load_err=1.
//  5 Backpressure and reload: hold in_valid high; in_ready=0 for exactly one
//    cycle per word. A new A5 after DONE sets cpu_reset=1 and load_done=0.
//  6 Reset during DATA: assert reset after 2 data bytes -> all outputs take
//    reset values immediately; the next frame loads from BASE_ADDR.

Source files
------------

// File: rtl/riscmacro_loader.sv
// Loads a framed byte stream (SYNC, 16-bit word count, words, checksum) into CPU memory through
// the override write port, and holds the CPU in reset until a frame loads with a good checksum.
module riscmacro_loader #(
    parameter int unsigned          BIT_WIDTH      = 32,
    parameter logic [BIT_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned          ADDR_STEP      = 4,
    parameter logic [7:0]           SYNC_BYTE      = 8'hA5,
    parameter int unsigned          TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 override_memwrite,
    output logic                 override_memread,
    output logic [BIT_WIDTH-1:0] override_rwaddr,
    output logic [BIT_WIDTH-1:0] override_rwdata,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StCsum, StDone, StErr
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tmo_q;
    logic [7:0]           len_hi_q;
    logic [15:0]          words_left_q;
    logic [1:0]           byte_cnt_q;
    logic [23:0]          word_q;
    logic [7:0]           csum_q;
    logic [BIT_WIDTH-1:0] addr_q;
    logic [BIT_WIDTH-1:0] rwaddr_q;
    logic [BIT_WIDTH-1:0] rwdata_q;
    logic                 cpu_reset_q;
    logic                 load_done_q;
    logic                 load_err_q;

    logic       accept;
    logic       is_sync;
    logic       timed;
    logic       tmo_hit;
    logic [7:0] csum_next;

    always_comb begin
        accept    = in_valid & in_ready;
        is_sync   = (in_data == SYNC_BYTE);
        csum_next = csum_q + in_data;
        timed     = (state_q == StLenHi) || (state_q == StLenLo) ||
                    (state_q == StData)  || (state_q == StCsum);
        tmo_hit   = timed && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end

    // State register; status outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= (state_d != StDone);
            load_done_q <= (state_d == StDone);
            load_err_q  <= (state_d == StErr);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: if (accept && is_sync) state_d = StLenHi;
            StLenHi: if (accept) state_d = StLenLo;
            StLenLo: begin
                if (accept) state_d = ({len_hi_q, in_data} == 16'd0) ? StCsum : StData;
            end
            StData:  if (accept && byte_cnt_q == 2'd3) state_d = StWrite;
            StWrite: state_d = (words_left_q == 16'd1) ? StCsum : StData;
            StCsum: begin
                if (accept) state_d = (csum_next == 8'd0) ? StDone : StErr;
            end
            default: state_d = StIdle;
        endcase
        if (tmo_hit) state_d = StErr;
    end

    always_comb begin
        in_ready          = (state_q != StWrite);
        override_memwrite = (state_q == StWrite);
        override_memread  = 1'b0;
        override_rwaddr   = rwaddr_q;
        override_rwdata   = rwdata_q;
        cpu_reset         = cpu_reset_q;
        load_done         = load_done_q;
        load_err          = load_err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q        <= '0;
            len_hi_q     <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            addr_q       <= BASE_ADDR;
            rwaddr_q     <= BASE_ADDR;
            rwdata_q     <= '0;
        end else begin
            // Idle counter restarts on any accept and on every state change.
            if (timed && !accept && (state_d == state_q)) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end

            if (accept) begin
                unique case (state_q)
                    StIdle, StDone, StErr: begin
                        if (is_sync) begin
                            csum_q     <= '0;
                            byte_cnt_q <= '0;
                        end
                    end
                    StLenHi: begin
                        len_hi_q <= in_data;
                        csum_q   <= csum_next;
                    end
                    StLenLo: begin
                        words_left_q <= {len_hi_q, in_data};
                        addr_q       <= BASE_ADDR;
                        byte_cnt_q   <= '0;
                        csum_q       <= csum_next;
                    end
                    StData: begin
                        word_q     <= {word_q[15:0], in_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        csum_q     <= csum_next;
                        if (byte_cnt_q == 2'd3) begin
                            rwaddr_q <= addr_q;
                            rwdata_q <= BIT_WIDTH'({word_q, in_data});
                        end
                    end
                    default: ;
                endcase
            end

            if (state_q == StWrite) begin
                addr_q       <= addr_q + BIT_WIDTH'(ADDR_STEP);
                words_left_q <= words_left_q - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_riscmacro_loader.sv
// Self-checking bench for riscmacro_loader: directed frame table, timeout, backpressure,
// mid-frame reset and randomized frames against a frame-level reference model.
module tb_riscmacro_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        override_memwrite;
    logic        override_memread;
    logic [31:0] override_rwaddr;
    logic [31:0] override_rwdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    riscmacro_loader #(
        .BIT_WIDTH     (32),
        .BASE_ADDR     (32'h0),
        .ADDR_STEP     (4),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .override_memwrite(override_memwrite),
        .override_memread (override_memread),
        .override_rwaddr  (override_rwaddr),
        .override_rwdata  (override_rwdata),
        .cpu_reset        (cpu_reset),
        .load_done        (load_done),
        .load_err         (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_words[$];
    bit          exp_good;
    bit          cnt_en = 0;
    int          low_cnt = 0;

    always @(negedge clk) begin
        if (override_memwrite) begin
            got_addr.push_back(override_rwaddr);
            got_data.push_back(override_rwdata);
        end
        if (cnt_en && !in_ready) low_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a byte and returns #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        bit acc;
        bit ok = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_bound", 32'd0, 32'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input bit gaps);
        foreach (fr[j]) begin
            send_byte(fr[j], 1'b0);
            if (gaps) idle($urandom_range(0, 3));
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] body[$]);
        int s = 0;
        foreach (body[j]) s += body[j];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Frame-level model: words follow the length field; load is good iff bytes after SYNC sum to 0.
    task automatic model_frame(input logic [7:0] fr[$]);
        int i = 0;
        int n;
        int s = 0;
        exp_words.delete();
        while (fr[i] != 8'hA5) i++;
        n = int'({fr[i+1], fr[i+2]});
        for (int k = 0; k < n; k++) begin
            exp_words.push_back({fr[i+3+4*k], fr[i+4+4*k], fr[i+5+4*k], fr[i+6+4*k]});
        end
        for (int j = i + 1; j < fr.size(); j++) s += fr[j];
        exp_good = ((s % 256) == 0);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_nwrites"}, got_addr.size(), exp_words.size());
        for (int k = 0; k < exp_words.size() && k < got_addr.size(); k++) begin
            check({tag, "_addr"}, got_addr[k], 32'(4 * k));
            check({tag, "_data"}, got_data[k], exp_words[k]);
        end
        check({tag, "_done"}, load_done, exp_good);
        check({tag, "_err"}, load_err, !exp_good);
        check({tag, "_cpu_reset"}, cpu_reset, !exp_good);
    endtask

    typedef struct {
        logic [7:0]  b[12];
        int          n;
        bit          done;
        int          nwr;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t        tbl[3];
    logic [7:0]  fr[$];
    logic [7:0]  body[$];
    bit          ok;

    initial begin
        #2_000_000;
        $display("FAIL global_bound: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0].b = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'hD8};
        tbl[0].n = 12; tbl[0].done = 1; tbl[0].nwr = 2;
        tbl[0].d0 = 32'h20010005; tbl[0].d1 = 32'h0;
        tbl[1].b = tbl[0].b;
        tbl[1].b[11] = 8'hD9;
        tbl[1].n = 12; tbl[1].done = 0; tbl[1].nwr = 2;
        tbl[1].d0 = 32'h20010005; tbl[1].d1 = 32'h0;
        tbl[2].b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].n = 4; tbl[2].done = 1; tbl[2].nwr = 0;
        tbl[2].d0 = 32'h0; tbl[2].d1 = 32'h0;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", load_done, 1'b0);
        check("rst_err", load_err, 1'b0);
        check("rst_memwrite", override_memwrite, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_addr", override_rwaddr, 32'h0);
        check("rst_data", override_rwdata, 32'h0);
        check("memread", override_memread, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed frames: good, bad checksum, empty.
        for (int t = 0; t < 3; t++) begin
            got_addr.delete(); got_data.delete();
            for (int j = 0; j < tbl[t].n; j++) send_byte(tbl[t].b[j], 1'b0);
            idle(2);
            check($sformatf("tbl%0d_done", t), load_done, tbl[t].done);
            check($sformatf("tbl%0d_err", t), load_err, !tbl[t].done);
            check($sformatf("tbl%0d_cpu_reset", t), cpu_reset, !tbl[t].done);
            check($sformatf("tbl%0d_nwr", t), got_addr.size(), tbl[t].nwr);
            if (tbl[t].nwr > 0 && got_addr.size() > 0) begin
                check($sformatf("tbl%0d_a0", t), got_addr[0], 32'h0);
                check($sformatf("tbl%0d_d0", t), got_data[0], tbl[t].d0);
            end
            if (tbl[t].nwr > 1 && got_addr.size() > 1) begin
                check($sformatf("tbl%0d_a1", t), got_addr[1], 32'h4);
                check($sformatf("tbl%0d_d1", t), got_data[1], tbl[t].d1);
            end
        end

        // Garbage then stall inside DATA until timeout.
        got_addr.delete(); got_data.delete();
        fr = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        send_frame(fr, 1'b0);
        check("tmo_cpu_reset_in_frame", cpu_reset, 1'b1);
        check("tmo_done_cleared", load_done, 1'b0);
        idle(TO - 5);
        check("tmo_not_early", load_err, 1'b0);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            idle(1);
            ok = load_err;
        end
        check("tmo_err", load_err, 1'b1);
        check("tmo_no_strobe", got_addr.size(), 0);
        check("tmo_cpu_reset", cpu_reset, 1'b1);

        // Backpressure with in_valid held high, then reload after DONE.
        got_addr.delete(); got_data.delete();
        body = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fr = body;
        fr.push_front(8'hA5);
        fr.push_back(csum_of(body));
        model_frame(fr);
        low_cnt = 0;
        cnt_en = 1;
        foreach (fr[j]) send_byte(fr[j], 1'b1);
        cnt_en = 0;
        in_valid = 1'b0;
        check("bp_ready_low_cycles", low_cnt, 3);
        compare_frame("bp");
        send_byte(8'hA5, 1'b0);
        check("reload_cpu_reset", cpu_reset, 1'b1);
        check("reload_done", load_done, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        check("reload_empty_done", load_done, 1'b1);

        // Asynchronous reset mid-word, then a fresh load from BASE_ADDR.
        got_addr.delete(); got_data.delete();
        fr = '{8'hA5, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_frame(fr, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_cpu_reset", cpu_reset, 1'b1);
        check("mid_rst_done", load_done, 1'b0);
        check("mid_rst_err", load_err, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_memwrite", override_memwrite, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_no_strobe", got_addr.size(), 0);
        fr = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(fr, 1'b0);
        idle(1);
        check("post_rst_nwr", got_addr.size(), 1);
        if (got_addr.size() > 0) begin
            check("post_rst_addr", got_addr[0], 32'h0);
            check("post_rst_data", got_data[0], 32'h11223344);
        end
        check("post_rst_done", load_done, 1'b1);

        // Randomized frames with leading garbage and gaps.
        for (int r = 0; r < 25; r++) begin
            int n;
            logic [7:0] g;
            got_addr.delete(); got_data.delete();
            fr.delete(); body.delete();
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                fr.push_back(g);
            end
            fr.push_back(8'hA5);
            n = $urandom_range(0, 4);
            body.push_back(8'h00);
            body.push_back(8'(n));
            repeat (4 * n) body.push_back(8'($urandom_range(0, 255)));
            foreach (body[j]) fr.push_back(body[j]);
            if ($urandom_range(0, 3) == 0) fr.push_back(csum_of(body) + 8'($urandom_range(1, 255)));
            else fr.push_back(csum_of(body));
            model_frame(fr);
            send_frame(fr, 1'b1);
            compare_frame($sformatf("rnd%0d", r));
        end
        check("memread_end", override_memread, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
